// File: rtl/fa_bist_checker.sv
// Built-in self-test engine for a full-adder cell: sweeps all eight {a,b,cin}
// vectors, compares s/cout against the ideal response and records the results.
module fa_bist_checker #(
    parameter int SETTLE = 1,
    parameter int ERR_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             cin,
    input  logic             s,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       fail_mask,
    output logic [2:0]       first_fail_vec,
    output logic             first_fail_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t     state, nxt_state;
    logic [2:0] idx, nxt_idx;
    logic [3:0] cnt, nxt_cnt;
    logic [2:0] vec_q;
    logic       launch;
    logic       sample;
    logic       mism;

    function automatic logic exp_sum(input logic [2:0] v);
        return v[2] ^ v[1] ^ v[0];
    endfunction

    function automatic logic exp_carry(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] e);
        return (e == {ERR_W{1'b1}}) ? e : e + ERR_W'(1);
    endfunction

    assign launch = (state == IDLE) && start;
    assign sample = (state == RUN) && (cnt == 4'd0);
    assign mism   = sample && ((s != exp_sum(idx)) || (cout != exp_carry(idx)));

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    nxt_state = RUN;
                    nxt_idx   = 3'd0;
                    nxt_cnt   = SETTLE_C;
                end
            end
            RUN: begin
                if (cnt != 4'd0) begin
                    nxt_cnt = cnt - 4'd1;
                end else if (idx != 3'd7) begin
                    nxt_idx = idx + 3'd1;
                    nxt_cnt = SETTLE_C;
                end else begin
                    nxt_state = DONE;
                end
            end
            DONE: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= 3'd0;
            cnt   <= 4'd0;
            vec_q <= 3'd0;
        end else begin
            state <= nxt_state;
            idx   <= nxt_idx;
            cnt   <= nxt_cnt;
            // Stimulus is registered from the next index so it lines up with busy.
            vec_q <= (nxt_state == RUN) ? nxt_idx : 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pass             <= 1'b0;
            err_count        <= '0;
            fail_mask        <= 8'h00;
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
        end else if (launch) begin
            pass             <= 1'b0;
            err_count        <= '0;
            fail_mask        <= 8'h00;
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
        end else if (sample) begin
            if (mism) begin
                fail_mask[idx] <= 1'b1;
                err_count      <= sat_inc(err_count);
                if (!first_fail_valid) begin
                    first_fail_vec   <= idx;
                    first_fail_valid <= 1'b1;
                end
            end
            // Verdict lands together with the last vector's result.
            if (idx == 3'd7) begin
                pass <= (err_count == '0) && !mism;
            end
        end
    end

    assign {a, b, cin} = vec_q;
    assign busy        = (state == RUN);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_fa_bist_checker.sv
// Directed bench for fa_bist_checker: three instances (SETTLE/ERR_W variants)
// each driving a behavioural full adder with selectable fault.
module tb_fa_bist_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_n_v, start_v;
    logic [2:0] a_v, b_v, cin_v, s_v, cout_v;
    logic [2:0] busy_v, done_v, pass_v, ffvalid_v;
    int         mode_v [3];
    logic [3:0] err0, err2;
    logic [1:0] err1;
    logic [7:0] mask0, mask1, mask2;
    logic [2:0] ffv0, ffv1, ffv2;

    int n_checks = 0;
    int n_fail   = 0;

    // mode 0: ideal, 1: cout stuck-at-0, 2: s inverted
    for (genvar g = 0; g < 3; g++) begin : g_model
        assign s_v[g]    = a_v[g] ^ b_v[g] ^ cin_v[g] ^ (mode_v[g] == 2);
        assign cout_v[g] = ((a_v[g] & b_v[g]) | (a_v[g] & cin_v[g]) | (b_v[g] & cin_v[g]))
                           & (mode_v[g] != 1);
    end

    fa_bist_checker #(.SETTLE(1), .ERR_W(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n_v[0]), .start(start_v[0]),
        .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .s(s_v[0]), .cout(cout_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err0),
        .fail_mask(mask0), .first_fail_vec(ffv0), .first_fail_valid(ffvalid_v[0])
    );

    fa_bist_checker #(.SETTLE(1), .ERR_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n_v[1]), .start(start_v[1]),
        .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .s(s_v[1]), .cout(cout_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err1),
        .fail_mask(mask1), .first_fail_vec(ffv1), .first_fail_valid(ffvalid_v[1])
    );

    fa_bist_checker #(.SETTLE(0), .ERR_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n_v[2]), .start(start_v[2]),
        .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .s(s_v[2]), .cout(cout_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err2),
        .fail_mask(mask2), .first_fail_vec(ffv2), .first_fail_valid(ffvalid_v[2])
    );

    function automatic logic [3:0] err_of(input int id);
        case (id)
            0:       return err0;
            1:       return {2'b00, err1};
            default: return err2;
        endcase
    endfunction

    function automatic logic [7:0] mask_of(input int id);
        case (id)
            0:       return mask0;
            1:       return mask1;
            default: return mask2;
        endcase
    endfunction

    function automatic logic [2:0] ffv_of(input int id);
        case (id)
            0:       return ffv0;
            1:       return ffv1;
            default: return ffv2;
        endcase
    endfunction

    function automatic logic [2:0] vec_of(input int id);
        return {a_v[id], b_v[id], cin_v[id]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input int id, input string tag);
        check({tag, "_busy"}, busy_v[id], 0);
        check({tag, "_done"}, done_v[id], 0);
        check({tag, "_pass"}, pass_v[id], 0);
        check({tag, "_err"}, err_of(id), 0);
        check({tag, "_mask"}, mask_of(id), 0);
        check({tag, "_ffvalid"}, ffvalid_v[id], 0);
        check({tag, "_ffvec"}, ffv_of(id), 0);
        check({tag, "_abc"}, vec_of(id), 0);
    endtask

    task automatic check_results(input int id, input string tag, input logic p,
                                 input logic [3:0] e, input logic [7:0] m,
                                 input logic v, input logic [2:0] f);
        check({tag, "_pass"}, pass_v[id], p);
        check({tag, "_err"}, err_of(id), e);
        check({tag, "_mask"}, mask_of(id), m);
        check({tag, "_ffvalid"}, ffvalid_v[id], v);
        check({tag, "_ffvec"}, ffv_of(id), f);
    endtask

    // Pulses start, then follows the sweep cycle by cycle; optionally pokes
    // start again mid-sweep. Ends one cycle after the DONE cycle.
    task automatic run_sweep(input int id, input int settle, input bit poke, input string tag);
        int k;
        @(negedge clk) start_v[id] = 1'b1;
        @(negedge clk) start_v[id] = 1'b0;
        check({tag, "_pass_cleared"}, pass_v[id], 0);
        check({tag, "_err_cleared"}, err_of(id), 0);
        check({tag, "_mask_cleared"}, mask_of(id), 0);
        k = 0;
        while (busy_v[id] && k < 40) begin
            k++;
            check({tag, "_vector"}, vec_of(id), (k - 1) / (settle + 1));
            check({tag, "_done_low"}, done_v[id], 0);
            if (poke && k == 3) start_v[id] = 1'b1;
            if (poke && k == 4) start_v[id] = 1'b0;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, k, 8 * (settle + 1));
        check({tag, "_done_pulse"}, done_v[id], 1);
        @(negedge clk);
        check({tag, "_done_width"}, done_v[id], 0);
        check({tag, "_busy_after"}, busy_v[id], 0);
        check({tag, "_abc_idle"}, vec_of(id), 0);
    endtask

    initial begin
        int k;
        int dones;
        rst_n_v  = 3'b000;
        start_v  = 3'b000;
        for (int i = 0; i < 3; i++) mode_v[i] = 0;
        repeat (3) @(negedge clk);
        check_zero(0, "reset0");
        check_zero(1, "reset1");
        check_zero(2, "reset2");
        rst_n_v = 3'b111;

        // Ideal adder, SETTLE=1
        run_sweep(0, 1, 1'b0, "ideal");
        check_results(0, "ideal", 1'b1, 4'd0, 8'h00, 1'b0, 3'd0);

        // cout stuck-at-0: vectors 3,5,6,7 fail
        mode_v[0] = 1;
        run_sweep(0, 1, 1'b0, "cout_sa0");
        check_results(0, "cout_sa0", 1'b0, 4'd4, 8'hE8, 1'b1, 3'd3);
        @(negedge clk);
        check_results(0, "cout_sa0_hold", 1'b0, 4'd4, 8'hE8, 1'b1, 3'd3);

        // s inverted with a 2-bit counter: every vector fails, count saturates
        mode_v[1] = 2;
        run_sweep(1, 1, 1'b0, "s_inv");
        check_results(1, "s_inv", 1'b0, 4'd3, 8'hFF, 1'b1, 3'd0);

        // SETTLE=0 with a start poke mid-sweep
        run_sweep(2, 0, 1'b1, "settle0");
        check_results(2, "settle0", 1'b1, 4'd0, 8'h00, 1'b0, 3'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_v[2] || busy_v[2]) dones++;
            @(negedge clk);
        end
        check("settle0_no_second_sweep", dones, 0);

        // Reset at vector 4 during a faulty sweep
        mode_v[0] = 1;
        @(negedge clk) start_v[0] = 1'b1;
        @(negedge clk) start_v[0] = 1'b0;
        k = 0;
        while (vec_of(0) != 3'd4 && k < 40) begin
            k++;
            @(negedge clk);
        end
        check("abort_reached_vec4", vec_of(0), 4);
        check("abort_mask_before", mask_of(0), 8'h08);
        rst_n_v[0] = 1'b0;
        @(negedge clk) rst_n_v[0] = 1'b1;
        check_zero(0, "abort");
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done_v[0]) dones++;
            @(negedge clk);
        end
        check("abort_no_done", dones, 0);

        mode_v[0] = 0;
        run_sweep(0, 1, 1'b0, "relaunch");
        check_results(0, "relaunch", 1'b1, 4'd0, 8'h00, 1'b0, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fa_bist_checker.md
# fa_bist_checker

Synthesizable built-in self-test engine for the `FullAdder` cell. It drives all eight `{a,b,cin}` input combinations into a full adder, samples the `s`/`cout` responses, and compares them against the expected sum and carry. It reports pass/fail, an error count, a per-vector fail mask and the first failing vector. It sits beside each adder instance as the on-chip counterpart of the bench stimulus.

## Interface
Parameters:
- `SETTLE`, default 1: extra cycles each vector is held before sampling; legal range 0..15.
- `ERR_W`, default 4: width of the error counter.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `start`  in  1  level; sampled high in IDLE to launch a sweep.
- `a`, `b`, `cin`  out  1 each  stimulus to the DUT; registered.
- `s`, `cout`  in  1 each  DUT response.
- `busy`  out  1  high while a sweep is running.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `pass`  out  1  high when the last sweep had zero mismatches; held until the next start.
- `err_count`  out  ERR_W  number of mismatching vectors, saturating.
- `fail_mask`  out  8  bit i set if vector i mismatched.
- `first_fail_vec`  out  3  index of the lowest-numbered failing vector.
- `first_fail_valid`  out  1  high if any vector failed.

## Operation
- Vector index i runs 0..7, with `{a,b,cin}` = i (`a` = MSB).
- Expected response: s = a^b^cin; cout = ab | a·cin | b·cin.
- A vector mismatches if either `s` or `cout` differs from the expected value.
- FSM states: IDLE, RUN, DONE.
  - IDLE, `start`=1 → RUN. On this transition: index←0, settle counter←SETTLE, `err_count`/`fail_mask`/`first_fail_*`/`pass` cleared.
  - RUN, settle counter>0 → decrement the counter, hold the vector.
  - RUN, settle counter=0 → sample and compare the response; update the results.
    - If index<7: index+1, counter←SETTLE.
    - If index=7: go to DONE.
  - DONE → IDLE unconditionally. `done`=1 and `pass`=(err_count==0) during the DONE cycle.
- On a mismatch at index i:
  - `fail_mask[i]`←1.
  - `err_count`←min(err_count+1, 2^ERR_W−1).
  - If `first_fail_valid`=0: `first_fail_vec`←i and `first_fail_valid`←1.
- `start` while in RUN or DONE is ignored. It is level-sampled only in IDLE, so holding `start` high re-launches on the cycle after DONE.
- Outside RUN, `a`/`b`/`cin` return to 0.
- Results (`pass`, `err_count`, `fail_mask`, `first_fail_*`) hold their values until the next launch or a reset.
- Reset values: every output is 0, state is IDLE, index is 0, counter is 0.
- Reset mid-sweep: the sweep aborts on that edge, all outputs go to their reset values, and `done` is not pulsed.

## Timing
- Let E0 be the edge at which `start` is sampled in IDLE.
  - Vector 0 appears on `a`/`b`/`cin` and `busy`=1 after E0.
- Each vector is driven for SETTLE+1 cycles. The response is sampled on the edge that ends the last of those cycles. The next vector is driven right after that same edge, with no gap.
- `busy` is high for exactly 8·(SETTLE+1) cycles.
  - At edge E0+8·(SETTLE+1), `busy` falls and `done` rises for one cycle.
  - At that edge, `pass`/`err_count`/`fail_mask` already reflect vector 7.
- Earliest relaunch: `start` sampled on the edge after the DONE cycle.
  - Sweep-to-sweep period is 8·(SETTLE+1)+2 cycles with `start` held high.
- The DUT path from `a`/`b`/`cin` to `s`/`cout` is combinational.
  - SETTLE=0 is legal only if that path meets one cycle.

## Test plan
- Ideal adder model, SETTLE=1: pulse `start` → `busy` high for 16 cycles, then `done` pulses for one cycle. Required result: `pass`=1, `err_count`=0, `fail_mask`=8'h00, `first_fail_valid`=0.
- `cout` stuck-at-0 → `fail_mask`=8'hE8 (vectors 3,5,6,7), `err_count`=4, `first_fail_vec`=3, `pass`=0.
- `s` inverted, ERR_W=2 → `fail_mask`=8'hFF, `err_count` saturates at 3, `first_fail_vec`=0.
- SETTLE=0, ideal model:
  - Vectors change every cycle; `done` pulses 8 cycles after the start edge.
  - Pulsing `start` again during `busy` has no effect: the sweep still ends at cycle 8 and there is no second `done`.
- Inject a fault, then drive `rst_n`=0 for one cycle at vector 4.
  - At the next edge all outputs are 0 and `done` never pulses.
  - A relaunch with an ideal model then gives `pass`=1 and `fail_mask`=8'h00; earlier results are fully cleared.
